mod_n_updown_counter: RTL and testbench

MOD_N_UPDOWN_COUNTER -- requirements
Module: mod_n_updown_counter

---
 rtl/counter_pkg.sv | 18 +
 rtl/cnt_prescaler.sv | 40 ++++
 rtl/mod_n_updown_counter.sv | 96 +++++++++
 tb/tb_mod_n_updown_counter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and parameter-legality helper for the modulo-N up/down counter.
package counter_pkg;

   localparam logic MODE_UP   = 1'b1;
   localparam logic MODE_DOWN = 1'b0;

   // Width is capped so that 2**width still fits comfortably in an int.
   function automatic bit params_legal(input int width, input int modulus, input int prescale);
      return (width >= 1) && (width <= 30) &&
             (modulus >= 2) && (modulus <= (1 << width)) &&
             (prescale >= 1);
   endfunction

   function automatic int prescale_width(input int prescale);
      return (prescale > 1) ? $clog2(prescale) : 1;
   endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Enable prescaler: ticks once every PRESCALE enabled cycles; clr restarts the count.
module cnt_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int PW = prescale_width(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
   localparam logic [PW-1:0] ONE  = PW'(1);

   logic [PW-1:0] cnt_q;
   logic [PW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with load, range-checked load and enable prescaler.
// Optional saturate select (port sat) is enabled by defining MOD_N_COUNTER_SAT_EN.
module mod_n_updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 12,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
`ifdef MOD_N_COUNTER_SAT_EN
   input  logic             sat,
`endif
   input  logic             en,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);

   if (!params_legal(WIDTH, MODULUS, PRESCALE)) begin : g_param_err
      $error("mod_n_updown_counter: illegal WIDTH/MODULUS/PRESCALE combination");
   end

   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;
   logic             tick;
   logic             sat_en;
   logic             over_range;
   logic             at_term;

`ifdef MOD_N_COUNTER_SAT_EN
   assign sat_en = sat;
`else
   assign sat_en = 1'b0;
`endif

   cnt_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (load),
      .tick (tick)
   );

   // Widened compare so MODULUS == 2**WIDTH never flags a load as out of range.
   assign over_range = ({1'b0, data_in} >= (WIDTH + 1)'(MODULUS));
   assign at_term    = (mode == MODE_UP) ? (cnt_q == MAX) : (cnt_q == '0);

   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      err_d  = 1'b0;
      if (load) begin
         cnt_d = over_range ? MAX : data_in;
         err_d = over_range;
      end else if (tick) begin
         if (at_term) begin
            if (!sat_en) begin
               cnt_d  = (mode == MODE_UP) ? '0 : MAX;
               wrap_d = 1'b1;
            end
         end else begin
            cnt_d = (mode == MODE_UP) ? cnt_q + ONE : cnt_q - ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
         err_q  <= err_d;
      end
   end

   assign data_out = cnt_q;
   assign tc       = at_term;
   assign wrap     = wrap_q;
   assign load_err = err_q;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Self-checking bench: two counters (PRESCALE 1 and 3) against an arithmetic reference model.
module tb_mod_n_updown_counter;

   localparam int W   = 4;
   localparam int MOD = 12;

   logic         clk;
   logic         rst;
   logic         en;
   logic         mode;
   logic         load;
   logic [W-1:0] data_in;
   logic         sat;

   logic [W-1:0] dout1, dout3;
   logic         tc1, tc3, wrap1, wrap3, err1, err3;

   int  n_tests = 0;
   int  n_fail  = 0;
   bit  chk_on  = 0;

   int  mc[2];
   int  mp[2];
   bit  mw[2];
   bit  me[2];
   int  ps[2] = '{1, 3};

   mod_n_updown_counter #(.WIDTH(W), .MODULUS(MOD), .PRESCALE(1)) dut (
      .clk      (clk),
      .rst      (rst),
`ifdef MOD_N_COUNTER_SAT_EN
      .sat      (sat),
`endif
      .en       (en),
      .mode     (mode),
      .load     (load),
      .data_in  (data_in),
      .data_out (dout1),
      .tc       (tc1),
      .wrap     (wrap1),
      .load_err (err1)
   );

   mod_n_updown_counter #(.WIDTH(W), .MODULUS(MOD), .PRESCALE(3)) dut3 (
      .clk      (clk),
      .rst      (rst),
`ifdef MOD_N_COUNTER_SAT_EN
      .sat      (sat),
`endif
      .en       (en),
      .mode     (mode),
      .load     (load),
      .data_in  (data_in),
      .data_out (dout3),
      .tc       (tc3),
      .wrap     (wrap3),
      .load_err (err3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: counts expressed as modular arithmetic on integers.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            mc[i] = 0; mp[i] = 0; mw[i] = 0; me[i] = 0;
         end else if (load) begin
            mp[i] = 0; mw[i] = 0;
            me[i] = (int'(data_in) >= MOD);
            mc[i] = me[i] ? MOD - 1 : int'(data_in);
         end else begin
            mw[i] = 0; me[i] = 0;
            if (en) begin
               mp[i] = mp[i] + 1;
               if (mp[i] == ps[i]) begin
                  mp[i] = 0;
                  if (sat && ((mode && mc[i] == MOD - 1) || (!mode && mc[i] == 0))) begin
                     mw[i] = 0;
                  end else if (mode) begin
                     mw[i] = (mc[i] == MOD - 1);
                     mc[i] = (mc[i] + 1) % MOD;
                  end else begin
                     mw[i] = (mc[i] == 0);
                     mc[i] = (mc[i] + MOD - 1) % MOD;
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("dout_p1", int'(dout1), mc[0]);
         chk("wrap_p1", int'(wrap1), int'(mw[0]));
         chk("err_p1",  int'(err1),  int'(me[0]));
         chk("tc_p1",   int'(tc1),   int'((mode && mc[0] == MOD - 1) || (!mode && mc[0] == 0)));
         chk("dout_p3", int'(dout3), mc[1]);
         chk("wrap_p3", int'(wrap3), int'(mw[1]));
         chk("err_p3",  int'(err3),  int'(me[1]));
         chk("tc_p3",   int'(tc3),   int'((mode && mc[1] == MOD - 1) || (!mode && mc[1] == 0)));
      end
   end

   task automatic step(input logic r, input logic e, input logic m, input logic l,
                       input logic [W-1:0] d);
      rst = r; en = e; mode = m; load = l; data_in = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      sat = 1'b0;
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
      chk_on = 1;
      chk("reset_dout", int'(dout1), 0);
      chk("reset_wrap", int'(wrap1), 0);
      chk("reset_err",  int'(err1),  0);

      // Up wrap
      step(1'b0, 1'b1, 1'b1, 1'b1, 4'd10);
      chk("up_load10", int'(dout1), 10);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      chk("up_11", int'(dout1), 11);
      chk("up_11_tc", int'(tc1), 1);
      chk("up_11_wrap", int'(wrap1), 0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      chk("up_0", int'(dout1), 0);
      chk("up_0_wrap", int'(wrap1), 1);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      chk("up_1", int'(dout1), 1);
      chk("up_1_wrap", int'(wrap1), 0);

      // Down wrap
      step(1'b0, 1'b1, 1'b0, 1'b1, 4'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      chk("dn_0", int'(dout1), 0);
      chk("dn_0_tc", int'(tc1), 1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      chk("dn_11", int'(dout1), 11);
      chk("dn_11_wrap", int'(wrap1), 1);

      // Out-of-range load
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'd14);
      chk("bad_load_dout", int'(dout1), 11);
      chk("bad_load_err", int'(err1), 1);
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'd5);
      chk("good_load_dout", int'(dout1), 5);
      chk("good_load_err", int'(err1), 0);

      // Simultaneous events
      step(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
      chk("rst_over_load", int'(dout1), 0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'd11);
      step(1'b0, 1'b1, 1'b1, 1'b1, 4'd3);
      chk("load_over_step", int'(dout1), 3);
      chk("load_no_wrap", int'(wrap1), 0);

      // Prescale by 3
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      for (int k = 1; k <= 6; k++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
         if (k == 2) chk("ps3_c2", int'(dout3), 0);
         if (k == 3) chk("ps3_c3", int'(dout3), 1);
         if (k == 6) chk("ps3_c6", int'(dout3), 2);
      end
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      chk("ps3_hold_c3", int'(dout3), 0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      chk("ps3_hold_c4", int'(dout3), 1);
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      chk("ps3_rst_mid", int'(dout3), 0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      chk("ps3_after_rst", int'(dout3), 1);

`ifdef MOD_N_COUNTER_SAT_EN
      sat = 1'b1;
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'd11);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
         chk("sat_hold", int'(dout1), 11);
         chk("sat_nowrap", int'(wrap1), 0);
      end
      sat = 1'b0;
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      chk("unsat_0", int'(dout1), 0);
      chk("unsat_wrap", int'(wrap1), 1);
`endif

      // Random traffic, checked every cycle by the compare process
      for (int k = 0; k < 3000; k++) begin
`ifdef MOD_N_COUNTER_SAT_EN
         sat = ($urandom_range(0, 3) == 0);
`endif
         step(($urandom_range(0, 49) == 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 7) < 5),
              ($urandom_range(0, 9) == 0),
              W'($urandom_range(0, 15)));
      end

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
